// File: rtl/serial_parallel_align.sv
// Serial-to-parallel deserialiser with comma-based word alignment and lock FSM.
// Optional macro SP_DISPARITY_COMMA_EN: also align on the inverted comma (other running disparity).
module serial_parallel_align #(
  parameter int              WIDTH      = 10,
  parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
  parameter int              LOCK_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             COMMA_OUT,
  output logic             LOCKED
);

  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   BIT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   BIT_ONE   = CW'(1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [3:0]      LOCK_TGT  = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_comma_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_comma;
  logic             r_locked;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic [3:0]       w_comma_cnt_nxt;
  logic [3:0]       w_comma_cnt_inc;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_comma_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_match;
  logic             w_boundary;

  // The word seen at this edge already includes the bit being sampled now.
  assign w_word          = {r_sr, DATA_IN};
  assign w_boundary      = (r_bit_cnt == BIT_LAST);
  assign w_comma_cnt_inc = r_comma_cnt + 4'd1;

`ifdef SP_DISPARITY_COMMA_EN
  assign w_match = (w_word == COMMA) || (w_word == ~COMMA);
`else
  assign w_match = (w_word == COMMA);
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_comma_nxt     = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_match) begin
          w_bit_cnt_nxt   = BIT_ZERO;
          w_comma_cnt_nxt = 4'd1;
          w_state_nxt     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_SYNC;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_SYNC: begin
        if (w_boundary) begin
          w_bit_cnt_nxt = BIT_ZERO;
          if (w_match) begin
            w_comma_cnt_nxt = w_comma_cnt_inc;
            w_state_nxt     = (w_comma_cnt_inc >= LOCK_TGT) ? ST_LOCKED : ST_SYNC;
          end else begin
            w_comma_cnt_nxt = 4'd0;
            w_state_nxt     = ST_SEARCH;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
        end
      end
      ST_LOCKED: begin
        if (w_boundary) begin
          w_bit_cnt_nxt = BIT_ZERO;
          w_data_nxt    = w_word;
          w_valid_nxt   = 1'b1;
          w_comma_nxt   = w_match;
        end else if (w_match) begin
          // Comma off the current boundary: the line slipped, re-align here.
          w_bit_cnt_nxt   = BIT_ZERO;
          w_comma_cnt_nxt = 4'd1;
          w_state_nxt     = ST_SYNC;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
        end
      end
      default: begin
        w_state_nxt     = ST_SEARCH;
        w_bit_cnt_nxt   = BIT_ZERO;
        w_comma_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_SEARCH;
      r_sr        <= {(WIDTH-1){1'b0}};
      r_bit_cnt   <= BIT_ZERO;
      r_comma_cnt <= 4'd0;
      r_data      <= {WIDTH{1'b0}};
      r_valid     <= 1'b0;
      r_comma     <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_word[WIDTH-2:0];
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_comma     <= w_comma_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign DATA_OUT  = r_data;
  assign VALID_OUT = r_valid;
  assign COMMA_OUT = r_comma;
  assign LOCKED    = r_locked;

endmodule
